// File: rtl/ppu_a12_filter_if.sv
// rtl/ppu_a12_filter_if.sv - cartridge pin inputs and conditioned A12/M2 event outputs
interface ppu_a12_filter_if;
  logic       ppu_a12;
  logic       cpu_m2;
  logic       cnt_clr;
  logic       a12_lvl;
  logic       a12_pe;
  logic       a12_ne;
  logic       a12_qpe;
  logic       m2_fall;
  logic [7:0] qpe_cnt;

  modport master (
    output ppu_a12, cpu_m2, cnt_clr,
    input  a12_lvl, a12_pe, a12_ne, a12_qpe, m2_fall, qpe_cnt
  );

  modport slave (
    input  ppu_a12, cpu_m2, cnt_clr,
    output a12_lvl, a12_pe, a12_ne, a12_qpe, m2_fall, qpe_cnt
  );
endinterface

// File: rtl/ppu_a12_filter.sv
// rtl/ppu_a12_filter.sv - A12/M2 synchroniser, A12 deglitcher and qualified-rise strobe generator
// Optional qualified-rise statistics counter enabled by defining A12_STAT_EN.
module ppu_a12_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int GLITCH_CYC  = 2,
  parameter int M2_LOW_MIN  = 3
) (
  input  logic              clk_i,
  input  logic              map_rst_i,
  ppu_a12_filter_if.slave   bus
);

  localparam logic [3:0] GLITCH_LAST = 4'(GLITCH_CYC - 1);
  localparam logic [3:0] LOW_MIN     = 4'(M2_LOW_MIN);

  logic [SYNC_STAGES-1:0] a12_sync_q;
  logic [SYNC_STAGES-1:0] m2_sync_q;
  logic                   a12_s;
  logic                   m2_s;

  logic                   m2_prev_q;
  logic                   m2_fall_q, m2_fall_d;
  logic [3:0]             gctr_q, gctr_d;
  logic                   lvl_q, lvl_d;
  logic                   pe_q, pe_d;
  logic                   ne_q, ne_d;
  logic                   qpe_q, qpe_d;
  logic [3:0]             low_ctr_q, low_ctr_d;

  assign a12_s = a12_sync_q[SYNC_STAGES-1];
  assign m2_s  = m2_sync_q[SYNC_STAGES-1];

  // A new level is accepted once GLITCH_CYC consecutive synced samples disagree with it.
  always_comb begin
    gctr_d = 4'd0;
    lvl_d  = lvl_q;
    pe_d   = 1'b0;
    ne_d   = 1'b0;
    if (a12_s != lvl_q) begin
      if (gctr_q == GLITCH_LAST) begin
        lvl_d = a12_s;
        pe_d  = a12_s;
        ne_d  = ~a12_s;
      end else begin
        gctr_d = gctr_q + 4'd1;
      end
    end
  end

  // Qualification uses the low time as it stood before this clock's update.
  always_comb begin
    m2_fall_d = m2_prev_q & ~m2_s;
    qpe_d     = pe_d & (low_ctr_q >= LOW_MIN);
    low_ctr_d = low_ctr_q;
    if (lvl_q) begin
      low_ctr_d = 4'd0;
    end else if (m2_fall_q && (low_ctr_q < LOW_MIN)) begin
      low_ctr_d = low_ctr_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (map_rst_i) begin
      a12_sync_q <= '0;
      m2_sync_q  <= '0;
      m2_prev_q  <= 1'b0;
      m2_fall_q  <= 1'b0;
      gctr_q     <= 4'd0;
      lvl_q      <= 1'b0;
      pe_q       <= 1'b0;
      ne_q       <= 1'b0;
      qpe_q      <= 1'b0;
      low_ctr_q  <= LOW_MIN;
    end else begin
      a12_sync_q <= {a12_sync_q[SYNC_STAGES-2:0], bus.ppu_a12};
      m2_sync_q  <= {m2_sync_q[SYNC_STAGES-2:0], bus.cpu_m2};
      m2_prev_q  <= m2_s;
      m2_fall_q  <= m2_fall_d;
      gctr_q     <= gctr_d;
      lvl_q      <= lvl_d;
      pe_q       <= pe_d;
      ne_q       <= ne_d;
      qpe_q      <= qpe_d;
      low_ctr_q  <= low_ctr_d;
    end
  end

`ifdef A12_STAT_EN
  logic [7:0] qpe_cnt_q, qpe_cnt_d;

  always_comb begin
    qpe_cnt_d = qpe_cnt_q;
    if (bus.cnt_clr) begin
      qpe_cnt_d = 8'h00;
    end else if (qpe_q && (qpe_cnt_q != 8'hFF)) begin
      qpe_cnt_d = qpe_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (map_rst_i) begin
      qpe_cnt_q <= 8'h00;
    end else begin
      qpe_cnt_q <= qpe_cnt_d;
    end
  end

  assign bus.qpe_cnt = qpe_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.qpe_cnt    = 8'h00;
`endif

  assign bus.a12_lvl = lvl_q;
  assign bus.a12_pe  = pe_q;
  assign bus.a12_ne  = ne_q;
  assign bus.a12_qpe = qpe_q;
  assign bus.m2_fall = m2_fall_q;

endmodule

// File: tb/tb_ppu_a12_filter.sv
// tb/tb_ppu_a12_filter.sv - bench for ppu_a12_filter: default instance plus a fast-path instance
// Optional statistics counter checks follow A12_STAT_EN.
module tb_ppu_a12_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a12 = 1'b0;
  logic m2  = 1'b0;
  logic clr = 1'b0;
  bit   chk_en = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ppu_a12_filter_if bus0 ();
  ppu_a12_filter_if bus1 ();

  assign bus0.ppu_a12 = a12;
  assign bus0.cpu_m2  = m2;
  assign bus0.cnt_clr = clr;
  assign bus1.ppu_a12 = a12;
  assign bus1.cpu_m2  = m2;
  assign bus1.cnt_clr = clr;

  ppu_a12_filter dut0 (
    .clk_i     (clk),
    .map_rst_i (rst),
    .bus       (bus0.slave)
  );

  ppu_a12_filter #(
    .SYNC_STAGES (3),
    .GLITCH_CYC  (1),
    .M2_LOW_MIN  (0)
  ) dut1 (
    .clk_i     (clk),
    .map_rst_i (rst),
    .bus       (bus1.slave)
  );

  // Reference model: window of recent synced samples, low time counted in M2 falls.
  int P_SYNC[2] = '{2, 3};
  int P_G[2]    = '{2, 1};
  int P_MIN[2]  = '{3, 0};

  logic [15:0] ahist[2];
  logic [15:0] mhist[2];
  logic [15:0] shist[2];
  int          nval[2];
  logic        m_prev[2];
  logic        e_lvl[2], e_pe[2], e_ne[2], e_qpe[2], e_fall[2];
  int          e_low[2];
  int          e_cnt[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ahist[i] = '0; mhist[i] = '0; shist[i] = '0; nval[i] = 0; m_prev[i] = 1'b0;
        e_lvl[i] = 1'b0; e_pe[i] = 1'b0; e_ne[i] = 1'b0; e_qpe[i] = 1'b0; e_fall[i] = 1'b0;
        e_low[i] = P_MIN[i];
        e_cnt[i] = 0;
      end else begin
        logic sa, sm, tog, old_lvl, old_fall, old_qpe, new_qpe;
        sa = ahist[i][P_SYNC[i]-1];
        sm = mhist[i][P_SYNC[i]-1];
        shist[i] = {shist[i][14:0], sa};
        if (nval[i] < 15) nval[i]++;
        tog = (nval[i] >= P_G[i]);
        for (int k = 0; k < P_G[i]; k++)
          if (shist[i][k] == e_lvl[i]) tog = 1'b0;
        old_lvl  = e_lvl[i];
        old_fall = e_fall[i];
        old_qpe  = e_qpe[i];
        new_qpe  = tog && !old_lvl && (e_low[i] >= P_MIN[i]);
        if (old_lvl) e_low[i] = 0;
        else if (old_fall && e_low[i] < P_MIN[i]) e_low[i]++;
        e_fall[i] = m_prev[i] & ~sm;
        m_prev[i] = sm;
        e_pe[i]  = tog & ~old_lvl;
        e_ne[i]  = tog & old_lvl;
        e_qpe[i] = new_qpe;
        if (tog) e_lvl[i] = ~old_lvl;
        if (clr) e_cnt[i] = 0;
        else if (old_qpe && e_cnt[i] < 255) e_cnt[i]++;
        ahist[i] = {ahist[i][14:0], a12};
        mhist[i] = {mhist[i][14:0], m2};
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] exp_vec(input int i);
    logic [7:0] c;
`ifdef A12_STAT_EN
    c = 8'(e_cnt[i]);
`else
    c = 8'h00;
`endif
    return {e_lvl[i], e_pe[i], e_ne[i], e_qpe[i], e_fall[i], c};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0_outputs", {19'd0, bus0.a12_lvl, bus0.a12_pe, bus0.a12_ne, bus0.a12_qpe,
                             bus0.m2_fall, bus0.qpe_cnt}, {19'd0, exp_vec(0)});
      check("dut1_outputs", {19'd0, bus1.a12_lvl, bus1.a12_pe, bus1.a12_ne, bus1.a12_qpe,
                             bus1.m2_fall, bus1.qpe_cnt}, {19'd0, exp_vec(1)});
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic m2_falls(input int n);
    for (int k = 0; k < n; k++) begin
      m2 = 1'b1; step(3);
      m2 = 1'b0; step(3);
    end
  endtask

  int pe_edge, pe_cnt, ne_cnt, qpe_cnt0, qpe_cnt1;
  bit qpe_seen;

  initial begin
    step(3);
    chk_en = 1'b1;
    check("reset_strobes", {27'd0, bus0.a12_lvl, bus0.a12_pe, bus0.a12_ne, bus0.a12_qpe,
                            bus0.m2_fall}, 32'd0);
    check("reset_qpe_cnt", {24'd0, bus0.qpe_cnt}, 32'd0);

    // Rise straight after reset: pe and qpe on the 4th edge.
    rst = 1'b0;
    a12 = 1'b1;
    pe_edge = -1; qpe_seen = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (bus0.a12_pe && pe_edge < 0) pe_edge = e;
      if (bus0.a12_qpe) qpe_seen = 1'b1;
    end
    check("t1_pe_edge", pe_edge, 4);
    check("t1_qpe_fresh", {31'd0, qpe_seen}, 32'd1);
    check("t1_lvl_high", {31'd0, bus0.a12_lvl}, 32'd1);

    // One-clock glitch is rejected.
    a12 = 1'b0; step(10);
    pe_cnt = 0; ne_cnt = 0;
    a12 = 1'b1; step(); a12 = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      pe_cnt += int'(bus0.a12_pe);
      ne_cnt += int'(bus0.a12_ne);
    end
    check("t2_glitch_pe", pe_cnt, 0);
    check("t2_glitch_ne", ne_cnt, 0);
    check("t2_glitch_lvl", {31'd0, bus0.a12_lvl}, 32'd0);

    // Two M2 falls are not enough, three are.
    for (int n = 2; n <= 3; n++) begin
      m2_falls(n);
      step(3);
      pe_cnt = 0; qpe_seen = 1'b0;
      a12 = 1'b1;
      for (int e = 0; e < 8; e++) begin
        step();
        pe_cnt += int'(bus0.a12_pe);
        if (bus0.a12_qpe) qpe_seen = 1'b1;
      end
      check($sformatf("t3_pe_%0d_falls", n), pe_cnt, 1);
      check($sformatf("t3_qpe_%0d_falls", n), {31'd0, qpe_seen}, (n == 3) ? 32'd1 : 32'd0);
      a12 = 1'b0; step(8);
    end

    // M2_LOW_MIN=0 instance: every rise is qualified without any M2 activity.
    qpe_cnt1 = 0;
    for (int p = 0; p < 8; p++) begin
      a12 = 1'b1;
      for (int e = 0; e < 3; e++) begin step(); qpe_cnt1 += int'(bus1.a12_qpe); end
      a12 = 1'b0;
      for (int e = 0; e < 3; e++) begin step(); qpe_cnt1 += int'(bus1.a12_qpe); end
    end
    step(6);
    check("t4_qpe_min0", qpe_cnt1, 8);

    // Reset lands while the deglitch count is partway through.
    a12 = 1'b0; step(8);
    a12 = 1'b1; step(3);
    rst = 1'b1; a12 = 1'b0; step();
    rst = 1'b0;
    pe_cnt = 0;
    for (int e = 0; e < 8; e++) begin step(); pe_cnt += int'(bus0.a12_pe); end
    check("t5_no_pe", pe_cnt, 0);
    check("t5_lvl_low", {31'd0, bus0.a12_lvl}, 32'd0);
    qpe_seen = 1'b0;
    a12 = 1'b1;
    for (int e = 0; e < 10; e++) begin step(); if (bus0.a12_qpe) qpe_seen = 1'b1; end
    check("t5_qpe_after_rst", {31'd0, qpe_seen}, 32'd1);
    a12 = 1'b0; step(6);

`ifdef A12_STAT_EN
    for (int p = 0; p < 300; p++) begin
      a12 = 1'b1; step(2);
      a12 = 1'b0; step(2);
    end
    step(6);
    check("t6_cnt_sat", {24'd0, bus1.qpe_cnt}, 32'd255);
    clr = 1'b1; qpe_seen = 1'b0;
    a12 = 1'b1;
    for (int e = 0; e < 4; e++) begin step(); if (bus1.a12_qpe) qpe_seen = 1'b1; end
    a12 = 1'b0;
    for (int e = 0; e < 4; e++) begin step(); if (bus1.a12_qpe) qpe_seen = 1'b1; end
    check("t6_qpe_under_clr", {31'd0, qpe_seen}, 32'd1);
    check("t6_cnt_cleared", {24'd0, bus1.qpe_cnt}, 32'd0);
    clr = 1'b0; step(2);
`endif

    // Randomised traffic; every cycle is compared against the model.
    begin
      int a_hold, m_hold;
      a_hold = 1; m_hold = 1;
      for (int c = 0; c < 3000; c++) begin
        if (--a_hold <= 0) begin a12 = ~a12; a_hold = $urandom_range(1, 7); end
        if (--m_hold <= 0) begin m2 = ~m2; m_hold = $urandom_range(1, 4); end
        clr = ($urandom_range(0, 99) == 0);
        rst = ($urandom_range(0, 499) == 0);
        step();
      end
      rst = 1'b0; clr = 1'b0;
      step(4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
